// File: rtl/mm_pkg.sv
// mm_pkg: shared state encoding and default widths for the matrix-multiply sequencer
package mm_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int OUT_DATA_WIDTH = 20;
  localparam int IDX_W = 4;
  localparam int N = 4;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMP, CAPT, EMIT, DONE} mm_state_t;
endpackage

// File: rtl/mm_idx_counter.sv
// mm_idx_counter: row-major 2-D index counter that wraps to (0,0) after (row_lim-1, col_lim-1)
module mm_idx_counter #(
  parameter int IDX_W = mm_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] row_lim,
  input  logic [IDX_W-1:0] col_lim,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             wrap_last
);
  logic w_col_end;
  assign w_col_end = col == col_lim - 1'b1;
  assign wrap_last = w_col_end && (row == row_lim - 1'b1);
  always_ff @(posedge clk)
    if (reset || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      col <= w_col_end ? '0 : col + 1'b1;
      row <= wrap_last ? '0 : w_col_end ? row + 1'b1 : row;
    end
endmodule

// File: rtl/mm_sequencer.sv
// mm_sequencer: loads A and B into the matrix-multiply helper, sweeps C[i][j] and streams results.
// Optional MM_SEQ_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module mm_sequencer import mm_pkg::*; #(
  parameter int DATA_WIDTH     = mm_pkg::DATA_WIDTH,
  parameter int N              = mm_pkg::N,
  parameter int IDX_W          = mm_pkg::IDX_W,
  parameter int OUT_DATA_WIDTH = mm_pkg::OUT_DATA_WIDTH
) (
`ifdef MM_SEQ_PERF_EN
  output logic [15:0]               perf_cycles,
`endif
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [IDX_W-1:0]          dim_m,
  input  logic [IDX_W-1:0]          dim_k,
  input  logic [IDX_W-1:0]          dim_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      mm_wr_enable,
  output logic                      mm_compute_enable,
  output logic [DATA_WIDTH-1:0]     mm_in_data,
  output logic [IDX_W-1:0]          mm_i,
  output logic [IDX_W-1:0]          mm_j,
  output logic                      mm_is_first_mat,
  output logic [IDX_W-1:0]          mm_match_dim,
  input  logic [OUT_DATA_WIDTH-1:0] mm_out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  mm_state_t                 r_state;
  logic [IDX_W-1:0]          r_dim_m, r_dim_k, r_dim_n;
  logic [OUT_DATA_WIDTH-1:0] r_out_data;
  logic                      r_out_valid, r_out_last, r_err;
  logic                      w_load, w_idx_on, w_in_hs, w_dims_ok, w_clr, w_inc, w_wrap_last;
  logic [IDX_W-1:0]          w_row, w_col, w_row_lim, w_col_lim;

  assign w_dims_ok = (dim_m != '0) && (dim_m <= IDX_W'(N)) &&
                     (dim_k != '0) && (dim_k <= IDX_W'(N)) &&
                     (dim_n != '0) && (dim_n <= IDX_W'(N));
  assign w_load    = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_idx_on  = w_load || (r_state == COMP);
  assign w_in_hs   = w_load && in_valid;
  assign w_clr     = (r_state == IDLE) && start && w_dims_ok;
  assign w_inc     = w_in_hs || ((r_state == EMIT) && out_ready && !r_out_last);
  // The single counter walks A (m x k), then B (k x n), then C (m x n)
  assign w_row_lim = (r_state == LOAD_B) ? r_dim_k : r_dim_m;
  assign w_col_lim = (r_state == LOAD_A) ? r_dim_k : r_dim_n;

  mm_idx_counter #(.IDX_W(IDX_W)) u_idx (
    .clk(clk), .reset(reset), .clr(w_clr), .inc(w_inc),
    .row_lim(w_row_lim), .col_lim(w_col_lim),
    .row(w_row), .col(w_col), .wrap_last(w_wrap_last)
  );

  assign in_ready          = w_load;
  assign mm_wr_enable      = w_in_hs;
  assign mm_compute_enable = r_state == COMP;
  assign mm_in_data        = w_in_hs ? in_data : '0;
  assign mm_i              = w_idx_on ? w_row : '0;
  assign mm_j              = w_idx_on ? w_col : '0;
  assign mm_is_first_mat   = r_state != LOAD_B;
  assign mm_match_dim      = r_dim_k;
  assign out_valid         = r_out_valid;
  assign out_data          = r_out_data;
  assign out_last          = r_out_last;
  assign busy              = r_state != IDLE;
  assign done              = r_state == DONE;
  assign err               = r_err;

  always_ff @(posedge clk)
    if (reset) begin
      r_state     <= IDLE;
      r_dim_m     <= '0;
      r_dim_k     <= '0;
      r_dim_n     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && start && !w_dims_ok;
      case (r_state)
        IDLE:   if (w_clr) begin
                  r_dim_m <= dim_m;
                  r_dim_k <= dim_k;
                  r_dim_n <= dim_n;
                  r_state <= LOAD_A;
                end
        LOAD_A: if (w_in_hs && w_wrap_last) r_state <= LOAD_B;
        LOAD_B: if (w_in_hs && w_wrap_last) r_state <= COMP;
        COMP:   r_state <= CAPT;
        CAPT:   begin
                  r_out_data  <= mm_out_data;
                  r_out_valid <= 1'b1;
                  r_out_last  <= w_wrap_last;
                  r_state     <= EMIT;
                end
        EMIT:   if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_state     <= r_out_last ? DONE : COMP;
                end
        DONE:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end

`ifdef MM_SEQ_PERF_EN
  always_ff @(posedge clk)
    if (reset || w_clr) perf_cycles <= '0;
    else if ((r_state != IDLE) && (perf_cycles != 16'hFFFF)) perf_cycles <= perf_cycles + 1'b1;
`endif
endmodule

// File: tb/tb_mm_sequencer.sv
// tb_mm_sequencer: randomized checks of mm_sequencer against a matrix-product reference and a helper model
module tb_mm_sequencer;
  localparam int DW = 8, NN = 4, IW = 4, OW = 20;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [IW-1:0] dim_m = '0, dim_k = '0, dim_n = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, mm_wr_enable, mm_compute_enable, mm_is_first_mat;
  logic [DW-1:0] mm_in_data;
  logic [IW-1:0] mm_i, mm_j, mm_match_dim;
  logic [OW-1:0] mm_out_data = '0, out_data;
  logic          out_valid, out_last, busy, done, err;
`ifdef MM_SEQ_PERF_EN
  logic [15:0]   perf_cycles;
`endif

  int n_checks = 0, n_errors = 0;
  int ga[16], gb[16];
  int ha[16][16], hb[16][16];

  mm_sequencer #(.DATA_WIDTH(DW), .N(NN), .IDX_W(IW), .OUT_DATA_WIDTH(OW)) dut (
`ifdef MM_SEQ_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .clk(clk), .reset(reset), .start(start), .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mm_wr_enable(mm_wr_enable), .mm_compute_enable(mm_compute_enable), .mm_in_data(mm_in_data),
    .mm_i(mm_i), .mm_j(mm_j), .mm_is_first_mat(mm_is_first_mat), .mm_match_dim(mm_match_dim),
    .mm_out_data(mm_out_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Helper model: operand store plus a registered dot product over match_dim
  always @(posedge clk) begin
    int s;
    if (mm_wr_enable) begin
      if (mm_is_first_mat) ha[mm_i][mm_j] = int'($signed(mm_in_data));
      else hb[mm_i][mm_j] = int'($signed(mm_in_data));
    end
    if (mm_compute_enable) begin
      s = 0;
      for (int q = 0; q < int'(mm_match_dim); q++) s += ha[mm_i][q] * hb[q][mm_j];
      mm_out_data <= s[OW-1:0];
    end
  end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_c(input int k, input int n, input int i, input int j);
    int s;
    logic signed [OW-1:0] t;
    s = 0;
    for (int q = 0; q < k; q++) s += ga[i*k+q] * gb[q*n+j];
    t = s[OW-1:0];
    return int'(t);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {busy, in_ready, mm_wr_enable, mm_compute_enable, out_valid, out_last, done, err, mm_is_first_mat}, 9'b000000001);
    check({tag, "_bus"}, {mm_i, mm_j, mm_in_data, mm_match_dim}, 0);
    check({tag, "_out"}, out_data, 0);
  endtask

  task automatic run_job(input int m, input int k, input int n, input int mode, input bit gaps, input bit bstart);
    int tot_in, tot, idx, g, res, comps, hold, r, c, e;
    bit saw_done;
    logic [17:0] wv;
    int exp_c[$];
    tot_in = m*k + k*n;
    tot = m*n;
    for (int i = 0; i < m; i++) for (int j = 0; j < n; j++) exp_c.push_back(ref_c(k, n, i, j));
    @(negedge clk);
    start = 1'b1; dim_m = IW'(m); dim_k = IW'(k); dim_n = IW'(n);
    @(negedge clk);
    start = 1'b0;
    check("busy_on", busy, 1);
    idx = 0; g = 0;
    while (idx < tot_in && g < 1000) begin
      @(negedge clk); g++;
      start = bstart && idx == 1;
      if (start) begin dim_m = 1; dim_k = 1; dim_n = 1; end
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < m*k) begin r = idx / k; c = idx % k; e = ga[idx]; end
      else begin r = (idx - m*k) / n; c = (idx - m*k) % n; e = gb[idx - m*k]; end
      in_data = DW'(e);
      #1;
      if (in_valid && in_ready) begin
        wv = {1'b1, idx < m*k, IW'(r), IW'(c), in_data};
        check("wr", {mm_wr_enable, mm_is_first_mat, mm_i, mm_j, mm_in_data}, wv);
        idx++;
      end else check("wr_gap", {mm_wr_enable, mm_in_data}, 0);
    end
    if (idx < tot_in) check("feed_timeout", idx, tot_in);
    res = 0; comps = 0; hold = 0; saw_done = 1'b0; g = 0;
    while (!saw_done && g < 2000) begin
      @(negedge clk); g++;
      start = 1'b0; in_valid = 1'b0;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : !(res == 1 && hold < 5);
      #1;
      check("no_load", {in_ready, mm_wr_enable}, 0);
      if (mm_compute_enable) begin
        comps++;
        check("match_dim", mm_match_dim, k);
      end
      if (out_valid) begin
        check("out_data", $signed(out_data), res < tot ? exp_c[res] : 0);
        check("out_last", out_last, res == tot - 1);
        if (out_ready) res++; else hold++;
      end
      if (done) saw_done = 1'b1;
    end
    if (!saw_done) check("done_timeout", 0, 1);
    check("res_cnt", res, tot);
    check("comp_cnt", comps, tot);
    @(negedge clk);
    #1;
    check("done_pulse", {done, busy}, 0);
  endtask

  task automatic illegal(input int m, input int k, input int n);
    @(negedge clk);
    start = 1'b1; dim_m = IW'(m); dim_k = IW'(k); dim_n = IW'(n);
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", {err, busy, in_ready}, 3'b100);
    @(negedge clk);
    check("err_clear", {err, busy, in_ready}, 0);
  endtask

  task automatic rand_fill(input int cnt_a, input int cnt_b);
    for (int i = 0; i < cnt_a; i++) ga[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < cnt_b; i++) gb[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("rst");
    ga[0:3] = '{1, 0, 0, 1};
    gb[0:3] = '{1, 2, 3, 4};
    run_job(2, 2, 2, 0, 1'b0, 1'b0);
    ga[0:5] = '{1, 2, 3, 4, 5, 6};
    gb[0:2] = '{1, 1, 1};
    run_job(2, 3, 1, 0, 1'b0, 1'b0);
    ga[0] = -3; gb[0] = 5;
    run_job(1, 1, 1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin ga[i] = -128; gb[i] = -128; end
    run_job(4, 4, 4, 0, 1'b0, 1'b0);
    rand_fill(6, 6);
    run_job(3, 2, 3, 2, 1'b1, 1'b1);
    illegal(5, 2, 2);
    illegal(2, 0, 2);
    illegal(2, 2, 0);
    rand_fill(4, 4);
    @(negedge clk);
    start = 1'b1; dim_m = 2; dim_k = 2; dim_n = 2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = DW'(i < 4 ? ga[i] : gb[i-4]);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("rst_mid");
    in_valid = 1'b0;
    run_job(2, 2, 2, 1, 1'b1, 1'b0);
    for (int t = 0; t < 6; t++) begin
      int m, k, n;
      m = $urandom_range(1, NN); k = $urandom_range(1, NN); n = $urandom_range(1, NN);
      rand_fill(m*k, k*n);
      run_job(m, k, n, 1, 1'b1, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mm_sequencer.md
Name: mm_sequencer

Overview:
Initiator-side controller for the matrix-multiply helper.
- Accepts a job, defined by dimensions plus a valid/ready element stream carrying A then B in row-major order.
- Drives the helper's write port to load both operands.
- Sweeps every (i,j) with compute requests, captures each registered product-sum one cycle later, and streams results out with valid/ready and a last flag.
- Sits between the system data stream and the helper instance.

Parameters:
- DATA_WIDTH, 8, operand element width (signed).
- N, 4, maximum matrix dimension supported by the helper.
- IDX_W, 4, width of index/dimension buses; must match the helper index width.
- OUT_DATA_WIDTH, 20, result width (signed).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  job request; sampled only in IDLE.
- dim_m  in  IDX_W  rows of A.
- dim_k  in  IDX_W  cols of A = rows of B.
- dim_n  in  IDX_W  cols of B.
- in_valid  in  1  operand element valid.
- in_ready  out  1  sequencer accepts element.
- in_data  in  DATA_WIDTH  operand element.
- mm_wr_enable  out  1  helper write strobe.
- mm_compute_enable  out  1  helper compute strobe.
- mm_in_data  out  DATA_WIDTH  helper write data.
- mm_i  out  IDX_W  helper row index.
- mm_j  out  IDX_W  helper column index.
- mm_is_first_mat  out  1  1 = write targets A, 0 = write targets B.
- mm_match_dim  out  IDX_W  inner dimension, equal to the latched dim_k.
- mm_out_data  in  OUT_DATA_WIDTH  helper result, registered.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_DATA_WIDTH  C[i][j].
- out_last  out  1  high with the final C element.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last result handshake.
- err  out  1  one-cycle pulse when start carries illegal dimensions.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; counters 0.
  - mm_is_first_mat = 1, mm_match_dim = 0.
  - Reset mid-job aborts immediately; a partial output is discarded.
  - The helper's contents are not cleared by the sequencer.
- IDLE:
  - On start with 1 <= dim_m, dim_k, dim_n <= N: latch the dimensions, clear counters, go to LOAD_A.
  - On start with any dimension 0 or > N: pulse err the next cycle, stay in IDLE.
- LOAD_A:
  - in_ready = 1. Each in_valid&&in_ready cycle drives mm_wr_enable = 1, mm_is_first_mat = 1, mm_i/mm_j = current (r,c), mm_in_data = in_data, all combinationally in the same cycle.
  - c increments and wraps at dim_k, then r increments.
  - After element dim_m*dim_k is accepted, go to LOAD_B with r,c = 0.
- LOAD_B:
  - Same as LOAD_A with mm_is_first_mat = 0 and bounds dim_k x dim_n.
  - After the last element, go to COMP.
- COMP:
  - One cycle: mm_compute_enable = 1, mm_i = r, mm_j = c, mm_match_dim = dim_k. Go to CAPT.
- CAPT:
  - Register mm_out_data into out_data.
  - Set out_valid = 1; set out_last if (r,c) = (dim_m-1, dim_n-1). Go to EMIT.
- EMIT:
  - Hold out_data, out_valid, and out_last stable until out_ready.
  - On handshake: out_valid = 0. If last, go to DONE; otherwise advance (r,c) row-major and go to COMP.
- DONE:
  - Pulse done for one cycle, then return to IDLE.
- Global rules:
  - in_ready = 0 outside the LOAD states.
  - mm_wr_enable and mm_compute_enable are never both high.
  - start while busy is ignored.
  - Per-result cost is 3 cycles with out_ready tied high.
- Width rules:
  - Operands are signed; no arithmetic happens in this block.
  - Dimension compares are unsigned on IDX_W.
  - Element counters must reach N*N without overflow.

Optional Feature:
- Macro: MM_SEQ_PERF_EN.
- Defined: adds output perf_cycles [15:0].
  - Cleared when a job is accepted; increments every busy cycle, saturating at 16'hFFFF.
  - Holds its value after done until the next accepted start. Reset value 0.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package mm_pkg holds:
  - the state enum (IDLE, LOAD_A, LOAD_B, COMP, CAPT, EMIT, DONE);
  - default widths (DATA_WIDTH = 8, OUT_DATA_WIDTH = 20, IDX_W = 4, N = 4).
- One sub-module, mm_idx_counter:
  - 2-D row/col counter with inputs clr, inc, row_lim, col_lim;
  - outputs row, col, wrap_last.
  - Instantiated once and reused across the load and compute phases.

Test Plan:
- Identity product: dims 2,2,2; A = [1,0,0,1], B = [1,2,3,4]; out_ready = 1 → outputs 1,2,3,4; out_last only on 4; done pulses once.
- Non-square: dims 2,3,1; A = [1,2,3,4,5,6], B = [1,1,1] → outputs 6, 15; mm_match_dim = 3 on every compute strobe.
- Signed / full range: dims 1,1,1; A = [-3], B = [5] → -15. Dims 4,4,4 with every element -128 → each output +65536 (20-bit); 16 outputs.
- Backpressure: out_ready low for 5 cycles on the 2nd result → out_data stable, no extra compute strobe, order unchanged. in_valid gaps during load → mm_wr_enable only on handshake cycles.
- Illegal start: dim_m = 5 (N = 4) or dim_k = 0 → err pulses, busy stays 0, in_ready stays 0. start while busy → ignored.
- Reset mid-job: assert reset during LOAD_B → next cycle all outputs 0, state IDLE. A following legal job completes correctly.
